// File: rtl/apx_acc_pkg.sv
// Shared types and saturating arithmetic for the approximate-adder window accumulator.
package apx_acc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } state_t;

    // Widest supported arithmetic container. Accumulators of up to 63 bits are
    // supported, so the sum of two in-range operands can never wrap here.
    localparam int ACC_W_LIM = 64;

    // Bounds of the widest container; narrowed to a real accumulator width by an
    // arithmetic right shift, which keeps the sign pattern (0111.. / 1000..).
    localparam logic signed [ACC_W_LIM-1:0] ACC_MAX = {1'b0, {(ACC_W_LIM-1){1'b1}}};
    localparam logic signed [ACC_W_LIM-1:0] ACC_MIN = {1'b1, {(ACC_W_LIM-1){1'b0}}};

    typedef struct packed {
        logic                 sat;
        logic [ACC_W_LIM-1:0] sum;
    } sat_sum_t;

    // Full-precision add, then clamp to the signed range of an acc_bits-wide accumulator.
    function automatic sat_sum_t sat_add(
        input logic signed [ACC_W_LIM-1:0] acc,
        input logic signed [ACC_W_LIM-1:0] sample,
        input int unsigned                 acc_bits
    );
        logic signed [ACC_W_LIM-1:0] full;
        logic signed [ACC_W_LIM-1:0] hi;
        logic signed [ACC_W_LIM-1:0] lo;
        sat_sum_t                    res;
        full = acc + sample;
        hi   = ACC_MAX >>> (ACC_W_LIM - acc_bits);
        lo   = ACC_MIN >>> (ACC_W_LIM - acc_bits);
        if (full > hi) begin
            res.sat = 1'b1;
            res.sum = hi;
        end else if (full < lo) begin
            res.sat = 1'b1;
            res.sum = lo;
        end else begin
            res.sat = 1'b0;
            res.sum = full;
        end
        return res;
    endfunction

endpackage

// File: rtl/apx_add_window_accumulator_acc.sv
// Registered accumulator datapath: signed saturating sum plus sticky sat/mix flags.
// Exposes the next-state values so the controller can capture a window as it closes.
module apx_sat_accumulator
    import apx_acc_pkg::*;
#(
    parameter int DATA_PATH_BITWIDTH = 32,
    parameter int ACC_BITWIDTH       = 40
) (
    input  logic                                 clk,
    input  logic                                 clear,
    input  logic                                 load,
    input  logic                                 add,
    input  logic signed [DATA_PATH_BITWIDTH-1:0] sample,
    input  logic                                 sample_ctl,
    input  logic                                 tag,
    output logic signed [ACC_BITWIDTH-1:0]       acc_d,
    output logic                                 sat_d,
    output logic                                 mix_d
);

    logic signed [ACC_BITWIDTH-1:0] acc_q;
    logic                           sat_q;
    logic                           mix_q;
    sat_sum_t                       sum_res;
    logic                           unused_sum_bits;

    // Next accumulator state: load starts a window, add folds in one sample.
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
    always_comb begin
        sum_res = sat_add(ACC_W_LIM'(acc_q), ACC_W_LIM'(sample), ACC_BITWIDTH);
        acc_d   = acc_q;
        sat_d   = sat_q;
        mix_d   = mix_q;
        if (load) begin
            acc_d = ACC_BITWIDTH'(sample);
            sat_d = 1'b0;
            mix_d = 1'b0;
        end else if (add) begin
            acc_d = sum_res.sum[ACC_BITWIDTH-1:0];
            sat_d = sat_q | sum_res.sat;
            mix_d = mix_q | (sample_ctl != tag);
        end
    end

    // The clamped sum is already sign-extended above ACC_BITWIDTH; those bits carry no information.
    assign unused_sum_bits = ^sum_res;

    // Accumulator registers with synchronous clear.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (clear) begin
            acc_q <= '0;
            sat_q <= 1'b0;
            mix_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            sat_q <= sat_d;
            mix_q <= mix_d;
        end
    end

endmodule

// File: rtl/apx_add_window_accumulator.sv
// Window accumulator for the approximate adder result bus: sums win_len signed samples,
// tags the window with its apx_ctl mode and hands the total downstream over valid/ready.
module apx_add_window_accumulator
    import apx_acc_pkg::*;
#(
    parameter int DATA_PATH_BITWIDTH = 32,
    parameter int ACC_BITWIDTH       = 40,
    parameter int CNT_BITWIDTH       = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic signed [DATA_PATH_BITWIDTH-1:0] in_data,
    input  logic                                 in_apx_ctl,
    input  logic        [CNT_BITWIDTH-1:0]       win_len,
    input  logic                                 flush,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic signed [ACC_BITWIDTH-1:0]       out_sum,
    output logic        [CNT_BITWIDTH-1:0]       out_count,
    output logic                                 out_apx_ctl,
    output logic                                 out_sat,
    output logic                                 out_mix
);

    localparam logic [CNT_BITWIDTH-1:0] CNT_ONE = CNT_BITWIDTH'(1);

    state_t                         state_q, state_d;
    logic [CNT_BITWIDTH-1:0]        len_q, len_d;
    logic [CNT_BITWIDTH-1:0]        count_q, count_d;
    logic                           tag_q, tag_d;
    logic signed [ACC_BITWIDTH-1:0] out_sum_q, out_sum_d;
    logic [CNT_BITWIDTH-1:0]        out_count_q, out_count_d;
    logic                           out_apx_ctl_q, out_apx_ctl_d;
    logic                           out_sat_q, out_sat_d;
    logic                           out_mix_q, out_mix_d;

    logic                           accept;
    logic                           load;
    logic                           add;
    logic                           close;
    logic signed [ACC_BITWIDTH-1:0] acc_d;
    logic                           sat_d;
    logic                           mix_d;

    assign in_ready  = !rst && (state_q != HOLD);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == HOLD);

    assign out_sum     = out_sum_q;
    assign out_count   = out_count_q;
    assign out_apx_ctl = out_apx_ctl_q;
    assign out_sat     = out_sat_q;
    assign out_mix     = out_mix_q;

    apx_sat_accumulator #(
        .DATA_PATH_BITWIDTH(DATA_PATH_BITWIDTH),
        .ACC_BITWIDTH      (ACC_BITWIDTH)
    ) u_acc (
        .clk       (clk),
        .clear     (rst),
        .load      (load),
        .add       (add),
        .sample    (in_data),
        .sample_ctl(in_apx_ctl),
        .tag       (tag_q),
        .acc_d     (acc_d),
        .sat_d     (sat_d),
        .mix_d     (mix_d)
    );

    // Window control: open on the first sample, close on length or flush, hold until taken.
    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        count_d       = count_q;
        tag_d         = tag_q;
        load          = 1'b0;
        add           = 1'b0;
        close         = 1'b0;
        out_sum_d     = out_sum_q;
        out_count_d   = out_count_q;
        out_apx_ctl_d = out_apx_ctl_q;
        out_sat_d     = out_sat_q;
        out_mix_d     = out_mix_q;

        case (state_q)
            IDLE: begin
                // flush is meaningless with no open window.
                if (accept) begin
                    load    = 1'b1;
                    len_d   = (win_len == '0) ? CNT_ONE : win_len;
                    count_d = CNT_ONE;
                    tag_d   = in_apx_ctl;
                    state_d = ACCUM;
                    close   = (len_d == CNT_ONE);
                end
            end
            ACCUM: begin
                if (accept) begin
                    add     = 1'b1;
                    count_d = count_q + CNT_ONE;
                end
                // A sample arriving with flush is summed before the window closes.
                close = flush || (count_d == len_q);
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Capture the final window values so the result survives the next window opening.
        if (close) begin
            state_d       = HOLD;
            out_sum_d     = acc_d;
            out_count_d   = count_d;
            out_apx_ctl_d = tag_d;
            out_sat_d     = sat_d;
            out_mix_d     = mix_d;
        end
    end

    // Control and result registers; reset discards any partial or pending window.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            len_q         <= '0;
            count_q       <= '0;
            tag_q         <= 1'b0;
            out_sum_q     <= '0;
            out_count_q   <= '0;
            out_apx_ctl_q <= 1'b0;
            out_sat_q     <= 1'b0;
            out_mix_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            count_q       <= count_d;
            tag_q         <= tag_d;
            out_sum_q     <= out_sum_d;
            out_count_q   <= out_count_d;
            out_apx_ctl_q <= out_apx_ctl_d;
            out_sat_q     <= out_sat_d;
            out_mix_q     <= out_mix_d;
        end
    end

endmodule

// File: tb/tb_apx_add_window_accumulator.sv
// Directed bench for apx_add_window_accumulator, built with a 34-bit accumulator so that
// 32-bit samples can reach both clamp limits within a short window.
module tb_apx_add_window_accumulator;

    localparam int DW = 32;
    localparam int AW = 34;
    localparam int CW = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_data;
    logic                 in_apx_ctl;
    logic [CW-1:0]        win_len;
    logic                 flush;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [AW-1:0] out_sum;
    logic [CW-1:0]        out_count;
    logic                 out_apx_ctl;
    logic                 out_sat;
    logic                 out_mix;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    apx_add_window_accumulator #(
        .DATA_PATH_BITWIDTH(DW),
        .ACC_BITWIDTH      (AW),
        .CNT_BITWIDTH      (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_apx_ctl (in_apx_ctl),
        .win_len    (win_len),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_count  (out_count),
        .out_apx_ctl(out_apx_ctl),
        .out_sat    (out_sat),
        .out_mix    (out_mix)
    );

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    // Offer one sample for exactly one clock edge.
    task automatic send(input int d, input logic ctl, input logic fl);
        in_valid   = 1'b1;
        in_data    = d;
        in_apx_ctl = ctl;
        flush      = fl;
        step();
        in_valid   = 1'b0;
        flush      = 1'b0;
    endtask

    task automatic check_win(input string tag, input logic signed [63:0] s, input int c,
                             input logic ctl, input logic sat, input logic mix);
        check({tag, ".valid"}, out_valid, 1);
        check({tag, ".sum"}, out_sum, s);
        check({tag, ".count"}, out_count, c);
        check({tag, ".apx_ctl"}, out_apx_ctl, ctl);
        check({tag, ".sat"}, out_sat, sat);
        check({tag, ".mix"}, out_mix, mix);
    endtask

    // Take the pending window and confirm the handshake completed.
    task automatic drain(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, ".drained"}, out_valid, 0);
        check({tag, ".ready_back"}, in_ready, 1);
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        in_apx_ctl = 1'b0;
        win_len    = '0;
        flush      = 1'b0;
        out_ready  = 1'b0;

        // Reset state.
        repeat (3) step();
        check("rst.in_ready", in_ready, 0);
        check("rst.out_valid", out_valid, 0);
        check("rst.out_sum", out_sum, 0);
        check("rst.out_count", out_count, 0);
        check("rst.out_apx_ctl", out_apx_ctl, 0);
        check("rst.out_sat", out_sat, 0);
        check("rst.out_mix", out_mix, 0);
        rst = 1'b0;
        #1;
        check("idle.in_ready", in_ready, 1);

        // Basic window: 10 - 3 + 7 + 100 = 114, result one cycle after the 4th accept.
        win_len = 8'd4;
        send(10, 1'b1, 1'b0);
        send(-3, 1'b1, 1'b0);
        send(7, 1'b1, 1'b0);
        check("basic.early_valid", out_valid, 0);
        check("basic.accum_ready", in_ready, 1);
        send(100, 1'b1, 1'b0);
        check_win("basic", 114, 4, 1'b1, 1'b0, 1'b0);

        // Backpressure: offered samples in HOLD must be refused and outputs must not move.
        in_valid = 1'b1;
        in_data  = 999;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp.valid", out_valid, 1);
            check("bp.in_ready", in_ready, 0);
            check("bp.sum", out_sum, 114);
            check("bp.count", out_count, 4);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp.release_valid", out_valid, 0);
        check("bp.release_ready", in_ready, 1);
        check("bp.sum_held", out_sum, 114);

        // Positive saturation: four samples reach 0x1_FFFFFFFC, the fifth clamps to ACC_MAX.
        win_len = 8'd5;
        for (int i = 0; i < 5; i++) send(32'h7FFF_FFFF, 1'b0, 1'b0);
        check_win("sat_pos", 64'sh1_FFFF_FFFF, 5, 1'b0, 1'b1, 1'b0);
        drain("sat_pos");

        // The next window starts with a clean sat flag.
        win_len = 8'd2;
        send(1, 1'b0, 1'b0);
        send(2, 1'b0, 1'b0);
        check_win("after_sat", 3, 2, 1'b0, 1'b0, 1'b0);
        drain("after_sat");

        // Negative clamp to -2^33, then a later +1 adds onto the clamped value.
        win_len = 8'd6;
        for (int i = 0; i < 5; i++) send(32'h8000_0000, 1'b0, 1'b0);
        send(1, 1'b0, 1'b0);
        check_win("sat_neg", -64'sd8589934591, 6, 1'b0, 1'b1, 1'b0);
        drain("sat_neg");

        // Flush together with the third sample: 5 + 6 + 7 = 18 over 3 samples.
        win_len = 8'd10;
        send(5, 1'b0, 1'b0);
        send(6, 1'b0, 1'b0);
        send(7, 1'b0, 1'b1);
        check_win("flush_with_sample", 18, 3, 1'b0, 1'b0, 1'b0);
        drain("flush_with_sample");

        // Flush while idle produces nothing and leaves the last result in place.
        flush = 1'b1;
        step();
        step();
        flush = 1'b0;
        check("flush_idle.valid", out_valid, 0);
        check("flush_idle.count_held", out_count, 3);

        // Flush alone closes a one-sample window.
        send(4, 1'b1, 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check_win("flush_only", 4, 1, 1'b1, 1'b0, 1'b0);
        drain("flush_only");

        // win_len of 0 acts as 1.
        win_len = 8'd0;
        send(-8, 1'b0, 1'b0);
        check_win("len0", -8, 1, 1'b0, 1'b0, 1'b0);
        drain("len0");

        // Mode change inside a window; win_len changes mid-window must be ignored.
        win_len = 8'd2;
        send(1, 1'b1, 1'b0);
        win_len = 8'd200;
        send(2, 1'b0, 1'b0);
        check_win("mix", 3, 2, 1'b1, 1'b0, 1'b1);
        drain("mix");

        // Reset mid-window discards the partial sum and the previous result.
        win_len = 8'd4;
        send(1, 1'b0, 1'b0);
        send(1, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        check("midrst.in_ready", in_ready, 0);
        check("midrst.out_valid", out_valid, 0);
        check("midrst.out_sum", out_sum, 0);
        check("midrst.out_count", out_count, 0);
        check("midrst.out_apx_ctl", out_apx_ctl, 0);
        check("midrst.out_sat", out_sat, 0);
        check("midrst.out_mix", out_mix, 0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) send(1, 1'b0, 1'b0);
        check("midrst.no_early_close", out_valid, 0);
        send(1, 1'b0, 1'b0);
        check_win("midrst.window", 4, 4, 1'b0, 1'b0, 1'b0);
        drain("midrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
